// File: rtl/gemm_operand_sequencer.sv
// ============================================================================
// Module      : gemm_operand_sequencer
// Description : Streams A/B/C operand rows from the matrix register file into
//               the systolic array, collects the result rows and writes them
//               back to the destination matrix register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_operand_sequencer #(
    parameter int DIM = 4,
    parameter int DW  = 16,
    parameter int RAW = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   flush,
    input  logic                   freeze,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [RAW-1:0]         rs1,
    input  logic [RAW-1:0]         rs2,
    input  logic [RAW-1:0]         rs3,
    input  logic [RAW-1:0]         rd,
    output logic                   mrf_ren,
    output logic [RAW-1:0]         mrf_raddr,
    output logic [$clog2(DIM)-1:0] mrf_rrow,
    input  logic [DIM*DW-1:0]      mrf_rdata,
    output logic                   sa_valid,
    output logic [1:0]             sa_sel,
    output logic [$clog2(DIM)-1:0] sa_row,
    output logic [DIM*DW-1:0]      sa_data,
    input  logic                   sa_out_valid,
    input  logic [DIM*DW-1:0]      sa_out_data,
    output logic                   mrf_wen,
    output logic [RAW-1:0]         mrf_waddr,
    output logic [$clog2(DIM)-1:0] mrf_wrow,
    output logic [DIM*DW-1:0]      mrf_wdata,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = $clog2(DIM);
    localparam int CW = $clog2(DIM + 1);

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_A    = 3'd1,
        S_RD_B    = 3'd2,
        S_RD_C    = 3'd3,
        S_COLLECT = 3'd4,
        S_WB      = 3'd5
    } state_t;

    state_t                state_q;
    logic [RAW-1:0]        rs1_q, rs2_q, rs3_q, rd_q;
    logic [RW-1:0]         cnt_q;
    logic [CW-1:0]         res_cnt_q;
    logic [DIM*DW-1:0]     buf_q [DIM];
    logic                  sa_valid_q;
    logic [1:0]            sa_sel_q;
    logic [RW-1:0]         sa_row_q;
    logic                  done_q;

    logic                  w_rd_phase;
    logic [1:0]            w_sel;
    logic [RAW-1:0]        w_idx;
    logic                  w_accept;

    // Operand select and source register for the current read phase
    always_comb begin
        w_sel = 2'd0;
        w_idx = '0;
        case (state_q)
            S_RD_A: begin w_sel = SEL_A; w_idx = rs1_q; end
            S_RD_B: begin w_sel = SEL_B; w_idx = rs2_q; end
            S_RD_C: begin w_sel = SEL_C; w_idx = rs3_q; end
            default: ;
        endcase
    end

    assign w_rd_phase = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_RD_C);

    // Reads/writes are gated by freeze and flush in the same cycle so a
    // stalled or aborted row never reaches the register file.
    assign mrf_ren   = w_rd_phase && !freeze && !flush;
    assign mrf_raddr = mrf_ren ? w_idx : '0;
    assign mrf_rrow  = mrf_ren ? cnt_q : '0;

    assign mrf_wen   = (state_q == S_WB) && !freeze && !flush;
    assign mrf_waddr = mrf_wen ? rd_q : '0;
    assign mrf_wrow  = mrf_wen ? cnt_q : '0;
    assign mrf_wdata = mrf_wen ? buf_q[cnt_q] : '0;

    // Flush takes priority, so a request seen during flush is not handshaked
    assign req_ready = (state_q == S_IDLE) && !freeze && !flush;
    assign w_accept  = req_valid && req_ready;

    assign sa_valid  = sa_valid_q;
    assign sa_sel    = sa_sel_q;
    assign sa_row    = sa_row_q;
    assign sa_data   = mrf_rdata;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    // Sequencer FSM, read pipeline register, result capture and writeback
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs3_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            res_cnt_q  <= '0;
            sa_valid_q <= 1'b0;
            sa_sel_q   <= 2'd0;
            sa_row_q   <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < DIM; i++) buf_q[i] <= '0;
        end else if (flush) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            res_cnt_q  <= '0;
            sa_valid_q <= 1'b0;
            sa_sel_q   <= 2'd0;
            sa_row_q   <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < DIM; i++) buf_q[i] <= '0;
        end else begin
            // A read issued last cycle is always delivered, even under freeze
            sa_valid_q <= mrf_ren;
            sa_sel_q   <= mrf_ren ? w_sel : 2'd0;
            sa_row_q   <= mrf_rrow;
            done_q     <= 1'b0;

            // Result rows may arrive in any busy state; surplus beats are dropped
            if ((state_q != S_IDLE) && sa_out_valid && (res_cnt_q < CW'(DIM))) begin
                buf_q[res_cnt_q[RW-1:0]] <= sa_out_data;
                res_cnt_q                <= res_cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        rs1_q     <= rs1;
                        rs2_q     <= rs2;
                        rs3_q     <= rs3;
                        rd_q      <= rd;
                        cnt_q     <= '0;
                        res_cnt_q <= '0;
                        state_q   <= S_RD_A;
                    end
                end
                S_RD_A, S_RD_B, S_RD_C: begin
                    if (!freeze) begin
                        if (cnt_q == RW'(DIM - 1)) begin
                            cnt_q   <= '0;
                            state_q <= (state_q == S_RD_A) ? S_RD_B :
                                       (state_q == S_RD_B) ? S_RD_C : S_COLLECT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (res_cnt_q == CW'(DIM)) begin
                        cnt_q   <= '0;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (!freeze) begin
                        if (cnt_q == RW'(DIM - 1)) begin
                            cnt_q     <= '0;
                            res_cnt_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gemm_operand_sequencer.sv
// ============================================================================
// Module      : tb_gemm_operand_sequencer
// Description : Scoreboard bench for gemm_operand_sequencer with an MRF model
//               and directed operand/result scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_operand_sequencer;

    localparam int DIM = 4;
    localparam int DW  = 16;
    localparam int RAW = 4;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              flush = 1'b0;
    logic              freeze = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [RAW-1:0]    rs1 = '0, rs2 = '0, rs3 = '0, rd = '0;
    logic              mrf_ren;
    logic [RAW-1:0]    mrf_raddr;
    logic [1:0]        mrf_rrow;
    logic [DIM*DW-1:0] mrf_rdata = '0;
    logic              sa_valid;
    logic [1:0]        sa_sel;
    logic [1:0]        sa_row;
    logic [DIM*DW-1:0] sa_data;
    logic              sa_out_valid = 1'b0;
    logic [DIM*DW-1:0] sa_out_data = '0;
    logic              mrf_wen;
    logic [RAW-1:0]    mrf_waddr;
    logic [1:0]        mrf_wrow;
    logic [DIM*DW-1:0] mrf_wdata;
    logic              busy;
    logic              done;

    gemm_operand_sequencer #(.DIM(DIM), .DW(DW), .RAW(RAW)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .freeze(freeze),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs1(rs1), .rs2(rs2), .rs3(rs3), .rd(rd),
        .mrf_ren(mrf_ren), .mrf_raddr(mrf_raddr), .mrf_rrow(mrf_rrow), .mrf_rdata(mrf_rdata),
        .sa_valid(sa_valid), .sa_sel(sa_sel), .sa_row(sa_row), .sa_data(sa_data),
        .sa_out_valid(sa_out_valid), .sa_out_data(sa_out_data),
        .mrf_wen(mrf_wen), .mrf_waddr(mrf_waddr), .mrf_wrow(mrf_wrow), .mrf_wdata(mrf_wdata),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int sa_seen  = 0;
    int wr_seen  = 0;
    int done_cnt = 0;
    int ren_cnt  = 0;

    logic [79:0]       exp_sa [$];
    logic [79:0]       exp_wr [$];
    logic [DIM*DW-1:0] wmem  [16][DIM];
    logic [DIM-1:0]    wflag [16];
    logic              clr4 = 1'b0;

    // Operand row contents: element e of row `row` in register r is r*256+row*16+e
    function automatic logic [DIM*DW-1:0] rowval(input int r, input int row);
        logic [DIM*DW-1:0] v;
        for (int e = 0; e < DIM; e++) v[e*DW +: DW] = 16'(r*256 + row*16 + e);
        return v;
    endfunction

    // Result row k of an operation tagged `tag`
    function automatic logic [DIM*DW-1:0] resval(input int tag, input int k);
        logic [DIM*DW-1:0] v;
        for (int e = 0; e < DIM; e++) v[e*DW +: DW] = 16'(tag*256 + k*16 + e);
        return v;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // MRF model: registered read of the operand pattern, row writes recorded
    always @(posedge CLK) begin
        if (mrf_ren) mrf_rdata <= rowval(int'(mrf_raddr), int'(mrf_rrow));
        if (mrf_wen) begin
            wmem[mrf_waddr][mrf_wrow]  <= mrf_wdata;
            wflag[mrf_waddr][mrf_wrow] <= 1'b1;
        end
        if (clr4) wflag[4] <= '0;
    end

    // Monitor: pops expected beats/writes whenever the DUT presents one
    always @(negedge CLK) begin
        if (nRST) begin
            if (sa_valid) begin
                sa_seen++;
                if (exp_sa.size() == 0) chk("sa_unexpected", {8'(sa_sel), 8'(sa_row), sa_data}, '1);
                else chk("sa_beat", {8'(sa_sel), 8'(sa_row), sa_data}, exp_sa.pop_front());
            end
            if (mrf_wen) begin
                wr_seen++;
                if (exp_wr.size() == 0) chk("wr_unexpected", {8'(mrf_waddr), 8'(mrf_wrow), mrf_wdata}, '1);
                else chk("wr_row", {8'(mrf_waddr), 8'(mrf_wrow), mrf_wdata}, exp_wr.pop_front());
            end
            if (done)    done_cnt++;
            if (mrf_ren) ren_cnt++;
        end
    end

    task automatic push_op(input int r1, input int r2, input int r3, input int rdst,
                           input int tag, input int nwr);
        for (int r = 0; r < DIM; r++) exp_sa.push_back({8'd0, 8'(r), rowval(r1, r)});
        for (int r = 0; r < DIM; r++) exp_sa.push_back({8'd1, 8'(r), rowval(r2, r)});
        for (int r = 0; r < DIM; r++) exp_sa.push_back({8'd2, 8'(r), rowval(r3, r)});
        for (int k = 0; k < nwr; k++) exp_wr.push_back({8'(rdst), 8'(k), resval(tag, k)});
    endtask

    task automatic issue(input int r1, input int r2, input int r3, input int rdst);
        @(negedge CLK);
        rs1 = RAW'(r1); rs2 = RAW'(r2); rs3 = RAW'(r3); rd = RAW'(rdst);
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic send_results(input int tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            sa_out_valid = 1'b1;
            sa_out_data  = resval(tag, k);
        end
        @(negedge CLK);
        sa_out_valid = 1'b0;
        sa_out_data  = '0;
    endtask

    task automatic wait_sa(input int target);
        int t = 0;
        while (sa_seen < target && t < 200) begin @(negedge CLK); t++; end
        if (sa_seen < target) timeout("wait_sa");
    endtask

    task automatic wait_done();
        int t = 0;
        do begin @(negedge CLK); t++; end while (!done && t < 200);
        if (!done) timeout("wait_done");
    endtask

    task automatic wait_read(input int addr, input int row);
        int t = 0;
        do begin @(negedge CLK); t++; end
        while (!(mrf_ren && mrf_raddr == RAW'(addr) && mrf_rrow == 2'(row)) && t < 200);
        if (!mrf_ren) timeout("wait_read");
    endtask

    task automatic check_mrf(input int rdst, input int tag);
        for (int k = 0; k < DIM; k++) chk("mrf_content", {16'(k), wmem[rdst][k]}, {16'(k), resval(tag, k)});
    endtask

    initial begin
        int b, d0, r0, t;

        // ---------------- reset state
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("reset_req_ready", 80'(req_ready), 80'(1));
        chk("reset_outputs", {76'(0), busy, mrf_ren, sa_valid, mrf_wen}, 80'(0));
        chk("reset_done", 80'(done), 80'(0));

        // ---------------- basic operation rs1=1 rs2=2 rs3=3 rd=4
        b = sa_seen; d0 = done_cnt; r0 = ren_cnt;
        push_op(1, 2, 3, 4, 8'hA1, 4);
        issue(1, 2, 3, 4);
        wait_sa(b + 12);
        repeat (3) @(negedge CLK);
        send_results(8'hA1, 4);
        wait_done();
        repeat (3) @(negedge CLK);
        chk("basic_ren_cycles", 80'(ren_cnt - r0), 80'(12));
        chk("basic_done_pulses", 80'(done_cnt - d0), 80'(1));
        check_mrf(4, 8'hA1);

        // ---------------- freeze 3 cycles during RD_B row 2
        b = sa_seen;
        push_op(1, 2, 3, 5, 8'hB2, 4);
        issue(1, 2, 3, 5);
        wait_read(2, 2);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("freeze_ren_low", {78'(0), mrf_ren, req_ready}, 80'(0));
        end
        freeze = 1'b0;
        #1;
        chk("freeze_resume", {8'(mrf_ren), 8'(mrf_raddr), 64'(mrf_rrow)}, {8'd1, 8'd2, 64'd2});
        wait_sa(b + 12);
        send_results(8'hB2, 4);
        wait_done();
        check_mrf(5, 8'hB2);

        // ---------------- flush during WB after 2 rows
        @(negedge CLK); clr4 = 1'b1;
        @(negedge CLK); clr4 = 1'b0;
        b = sa_seen; d0 = done_cnt;
        push_op(1, 2, 3, 4, 8'hC3, 2);
        issue(1, 2, 3, 4);
        wait_sa(b + 12);
        send_results(8'hC3, 4);
        t = 0;
        do begin @(negedge CLK); t++; end while (!(mrf_wen && mrf_wrow == 2'd1) && t < 200);
        if (!mrf_wen) timeout("wait_wb_row1");
        @(posedge CLK); #1 flush = 1'b1;
        @(posedge CLK); #1 flush = 1'b0;
        @(negedge CLK);
        chk("flush_busy_done", {78'(0), busy, done}, 80'(0));
        repeat (5) @(negedge CLK);
        chk("flush_no_done", 80'(done_cnt - d0), 80'(0));
        chk("flush_rows_written", 80'(wflag[4]), 80'(4'b0011));
        chk("flush_row0", 80'(wmem[4][0]), 80'(resval(8'hC3, 0)));
        chk("flush_row1", 80'(wmem[4][1]), 80'(resval(8'hC3, 1)));

        // ---------------- six result beats starting during RD_C
        b = sa_seen;
        push_op(1, 2, 3, 6, 8'hD4, 4);
        issue(1, 2, 3, 6);
        wait_read(3, 0);
        send_results(8'hD4, 6);
        wait_sa(b + 12);
        wait_done();
        repeat (3) @(negedge CLK);
        check_mrf(6, 8'hD4);

        // ---------------- request held while busy with a different rd
        b = sa_seen;
        push_op(1, 2, 3, 7, 8'hE5, 4);
        push_op(1, 2, 3, 9, 8'hF6, 4);
        @(negedge CLK);
        rs1 = 4'd1; rs2 = 4'd2; rs3 = 4'd3; rd = 4'd7;
        req_valid = 1'b1;
        @(posedge CLK); #1 rd = 4'd9;
        @(negedge CLK);
        chk("busy_not_ready", {78'(0), busy, req_ready}, {78'(0), 1'b1, 1'b0});
        wait_sa(b + 12);
        send_results(8'hE5, 4);
        wait_done();
        chk("ready_after_done", 80'(req_ready), 80'(1));
        @(posedge CLK); #1 req_valid = 1'b0;
        chk("held_req_accepted", 80'(busy), 80'(1));
        wait_sa(b + 24);
        send_results(8'hF6, 4);
        wait_done();
        repeat (2) @(negedge CLK);
        check_mrf(7, 8'hE5);
        check_mrf(9, 8'hF6);

        // ---------------- asynchronous reset mid-RD_A
        push_op(1, 2, 3, 4, 8'h17, 4);
        issue(1, 2, 3, 4);
        wait_read(1, 1);
        #2 nRST = 1'b0;
        #1;
        chk("areset_outputs", {75'(0), busy, mrf_ren, sa_valid, mrf_wen, done}, 80'(0));
        exp_sa.delete();
        exp_wr.delete();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("areset_idle", {78'(0), busy, req_ready}, {78'(0), 1'b0, 1'b1});
        b = sa_seen; d0 = done_cnt;
        push_op(1, 2, 3, 4, 8'h28, 4);
        issue(1, 2, 3, 4);
        wait_sa(b + 12);
        send_results(8'h28, 4);
        wait_done();
        repeat (3) @(negedge CLK);
        chk("areset_done_pulses", 80'(done_cnt - d0), 80'(1));
        check_mrf(4, 8'h28);

        chk("sa_queue_drained", 80'(exp_sa.size()), 80'(0));
        chk("wr_queue_drained", 80'(exp_wr.size()), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
